score_recorder: RTL and testbench



---
 rtl/score_recorder.sv | 99 +++++++++
 tb/tb_score_recorder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/score_recorder.sv
// rtl/score_recorder.sv - round score counter that writes each final score into a 32-slot score memory
// One registered memory write per concluded game; the slot pointer wraps so the newest 32 games are kept.
module score_recorder #(
  parameter int unsigned MAX_SCORE = 999
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       point,
  input  logic       game_over,
  output logic [9:0] score,
  output logic [4:0] address,
  output logic [9:0] data,
  output logic       wren,
  output logic [5:0] games_recorded,
  output logic       playing
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [9:0] MaxScoreC  = 10'(MAX_SCORE);
  localparam logic [5:0] MaxGamesC  = 6'd32;

  state_t     state_q;
  logic [9:0] score_q;
  logic [9:0] data_q;
  logic [4:0] address_q;
  logic [4:0] wr_ptr_q;
  logic       wren_q;
  logic       playing_q;
  logic [5:0] games_q;

  // A point on the game-over edge still counts, so the final score uses this value too.
  logic [9:0] score_d;
  always_comb begin
    score_d = score_q;
    if (point && (score_q < MaxScoreC)) begin
      score_d = score_q + 10'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      score_q   <= '0;
      data_q    <= '0;
      address_q <= '0;
      wr_ptr_q  <= '0;
      wren_q    <= 1'b0;
      playing_q <= 1'b0;
      games_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            score_q   <= '0;
            playing_q <= 1'b1;
            state_q   <= PLAY;
          end
        end
        PLAY: begin
          score_q <= score_d;
          if (game_over) begin
            data_q    <= score_d;
            address_q <= wr_ptr_q;
            wren_q    <= 1'b1;
            playing_q <= 1'b0;
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          // The memory captures the write on this edge; only now is the slot consumed.
          wren_q   <= 1'b0;
          wr_ptr_q <= wr_ptr_q + 5'd1;
          if (games_q < MaxGamesC) begin
            games_q <= games_q + 6'd1;
          end
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign score          = score_q;
  assign address        = address_q;
  assign data           = data_q;
  assign wren           = wren_q;
  assign games_recorded = games_q;
  assign playing        = playing_q;

endmodule

// File: tb/tb_score_recorder.sv
// tb/tb_score_recorder.sv - directed self-checking bench for score_recorder
module tb_score_recorder;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic       point;
  logic       game_over;
  logic [9:0] score;
  logic [4:0] address;
  logic [9:0] data;
  logic       wren;
  logic [5:0] games_recorded;
  logic       playing;

  int n_checks = 0;
  int n_fail   = 0;

  score_recorder #(.MAX_SCORE(999)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .point          (point),
    .game_over      (game_over),
    .score          (score),
    .address        (address),
    .data           (data),
    .wren           (wren),
    .games_recorded (games_recorded),
    .playing        (playing)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic p, input logic g);
    @(negedge clock);
    start = s; point = p; game_over = g;
    @(posedge clock);
    #1;
    start = 1'b0; point = 1'b0; game_over = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic run_game(input int pts, input logic [4:0] exp_addr, input int exp_games);
    step(1, 0, 0);
    for (int i = 0; i < pts; i++) step(0, 1, 0);
    step(0, 0, 1);
    check("game_wren", wren, 1);
    check("game_addr", address, exp_addr);
    check("game_data", data, pts);
    step(0, 0, 0);
    check("game_wren_off", wren, 0);
    check("game_count", games_recorded, exp_games);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; point = 1'b0; game_over = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_score", score, 0);
    check("rst_addr", address, 0);
    check("rst_data", data, 0);
    check("rst_wren", wren, 0);
    check("rst_games", games_recorded, 0);
    check("rst_playing", playing, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // IDLE ignores point and game_over
    step(0, 1, 0);
    step(0, 0, 1);
    check("idle_score", score, 0);
    check("idle_wren", wren, 0);
    check("idle_playing", playing, 0);

    // First game: 5 points
    step(1, 0, 0);
    check("start_playing", playing, 1);
    check("start_score", score, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    check("g1_score", score, 5);
    step(0, 0, 1);
    check("g1_wren", wren, 1);
    check("g1_addr", address, 0);
    check("g1_data", data, 5);
    check("g1_playing", playing, 0);
    step(0, 0, 0);
    check("g1_wren_off", wren, 0);
    check("g1_games", games_recorded, 1);
    step(0, 1, 0);
    step(0, 0, 1);
    check("done_score", score, 5);
    check("done_wren", wren, 0);
    check("done_data_hold", data, 5);

    // Second game: start ignored in PLAY, coincident point+game_over at 7
    step(1, 0, 0);
    check("restart_score", score, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    step(1, 0, 0);
    check("play_start_ign", score, 3);
    check("play_start_playing", playing, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    check("g2_pre", score, 7);
    step(0, 1, 1);
    check("g2_wren", wren, 1);
    check("g2_addr", address, 1);
    check("g2_data", data, 8);
    check("g2_score", score, 8);
    step(0, 0, 0);
    check("g2_wren_off", wren, 0);
    check("g2_games", games_recorded, 2);

    // Third game: saturation at 999
    step(1, 0, 0);
    for (int i = 0; i < 1005; i++) step(0, 1, 0);
    check("sat_score", score, 999);
    step(0, 0, 1);
    check("sat_wren", wren, 1);
    check("sat_addr", address, 2);
    check("sat_data", data, 999);
    step(0, 0, 0);
    check("sat_games", games_recorded, 3);

    // start coincident with game_over: game_over wins
    step(1, 0, 0);
    step(0, 1, 0);
    step(1, 0, 1);
    check("sg_wren", wren, 1);
    check("sg_data", data, 1);
    check("sg_playing", playing, 0);
    step(0, 0, 0);
    check("sg_wren_off", wren, 0);
    check("sg_score", score, 1);
    check("sg_playing2", playing, 0);

    // Wrap-around: 33 games after reset
    do_reset();
    for (int g = 1; g <= 33; g++) begin
      run_game(g, 5'((g - 1) % 32), (g < 32) ? g : 32);
    end
    check("wrap_games", games_recorded, 32);

    // Reset while wren is high
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    check("rw_wren_hi", wren, 1);
    check("rw_addr", address, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rw_wren_async", wren, 0);
    check("rw_games", games_recorded, 0);
    check("rw_addr_rst", address, 0);
    check("rw_score", score, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    run_game(4, 5'd0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
